// File: rtl/reg_file_16x8.sv
// reg_file_16x8: 16 x 8 register file with two async read ports and one sync write port.
// Ports: clk, rst_n (async active-low clear), ra/rb (read addresses), wa/wd/we (write
// address, data, enable), read_a/read_b (combinational read data).
module reg_file_16x8 #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              we,
   output logic [DATA_W-1:0] read_a,
   output logic [DATA_W-1:0] read_b
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [DATA_W-1:0] r_mem [DEPTH];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      else if (we)
         r_mem[wa] <= wd;
   // no bypass: a same-address write shows up only after its edge
   assign read_a = r_mem[ra];
   assign read_b = r_mem[rb];
endmodule

// File: tb/tb_reg_file_16x8.sv
// tb_reg_file_16x8: directed self-checking bench for reg_file_16x8.
module tb_reg_file_16x8;
   logic       clk;
   logic       rst_n;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] wa;
   logic [7:0] wd;
   logic       we;
   logic [7:0] read_a;
   logic [7:0] read_b;
   logic [7:0] m [16];
   int vectors = 0;
   int miscompares = 0;

   reg_file_16x8 dut (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .wa(wa), .wd(wd), .we(we),
      .read_a(read_a), .read_b(read_b)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 16; i++) begin
         ra = 4'(i);
         rb = 4'(15 - i);
         #1;
         chk($sformatf("%s_a%0d", tag, i), read_a, m[i]);
         chk($sformatf("%s_b%0d", tag, 15 - i), read_b, m[15 - i]);
      end
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      sweep("reset0");
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wa = 4'(i); wd = 8'(i * 17); we = 1'b1;
         m[i] = 8'(i * 17);
         @(posedge clk);
         #1 we = 1'b0; ra = 4'(i);
         #1 chk($sformatf("fill%0d", i), read_a, m[i]);
      end
      sweep("dual");
      @(negedge clk);
      ra = 4'd3; rb = 4'd3; wa = 4'd3; wd = 8'hAA; we = 1'b1;
      #1;
      chk("rdw_old_a", read_a, 8'h33);
      chk("rdw_old_b", read_b, 8'h33);
      @(posedge clk);
      #1 we = 1'b0;
      chk("ovw_new_a", read_a, 8'hAA);
      chk("ovw_new_b", read_b, 8'hAA);
      m[3] = 8'hAA;
      sweep("ovw_nb");
      @(negedge clk);
      we = 1'b0; wa = 4'd5; wd = 8'h11;
      repeat (3) @(posedge clk);
      #1 ra = 4'd5;
      #1 chk("gate5", read_a, 8'h55);
      sweep("gate_nb");
      @(posedge clk);
      #2 rst_n = 1'b0;
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      sweep("areset");
      we = 1'b1; wa = 4'd7; wd = 8'h77;
      @(posedge clk);
      #1 ra = 4'd7;
      #1 chk("wr_in_reset", read_a, 8'h00);
      we = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      wa = 4'd0; wd = 8'h5A; we = 1'b1;
      @(posedge clk);
      #1 we = 1'b0; ra = 4'd0; rb = 4'd1;
      #1;
      chk("reg0_a", read_a, 8'h5A);
      chk("reg1_b", read_b, 8'h00);
      m[0] = 8'h5A;
      sweep("reg0_nb");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
